multilane_serializer: RTL
=========================

// Module: multilane_serializer
//
// PURPOSE
//  Parametrised successor to the single-bit serializer.
//  - Accepts a parallel word with a length field.
//  - Streams it out LANES bits per clock, MSB-first or LSB-first (per-transaction mode).
//  - A valid/ready input handshake plus a one-entry holding register lets consecutive words stream with no idle gap.
//  - Sits between a parallel producer and a serial/multi-lane line driver.
//
// PARAMETERS
//  DATA_BUS_WIDTH  16  Parallel word width W. Must be a multiple of LANES.
//  DATA_MOD_WIDTH  4   Width of data_mod_i; equals $clog2(W).
//  LANES           1   Output bits per beat (1, 2, 4, ...).
//  MIN_LEN         3   Shortest legal length; lengths 1..MIN_LEN-1 are dropped.
//
// PORTS
//  clk_i            in   1                Clock; all logic is on the posedge.
//  srst_i           in   1                Synchronous reset, active-high.
//  data_i           in   W                Parallel word.
//  data_mod_i       in   DATA_MOD_WIDTH   Length L in bits; 0 means L = W.
//  data_lsb_first_i in   1                1 = LSB-first, 0 = MSB-first.
//  data_val_i       in   1                Input word valid.
//  data_rdy_o       out  1                Input can accept; transfer when val & rdy at posedge.
//  ser_data_o       out  LANES            Beat data; lane LANES-1 carries the earliest bit in stream order.
//  ser_lanes_o      out  $clog2(LANES)+1  Count of valid lanes in this beat (top-aligned).
//  ser_data_val_o   out  1                Beat valid. No output backpressure.
//  ser_last_o       out  1                Final beat of the transaction.
//  busy_o           out  1                Shifter active or holding register full.
//
// BEHAVIOUR
//  - Reset: srst_i high at a posedge gives the following in the next cycle.
//    - Outputs: ser_data_val_o = 0, ser_last_o = 0, busy_o = 0, ser_data_o = 0, ser_lanes_o = 0, data_rdy_o = 1.
//    - State: holding register empty; any in-flight transaction is discarded with no last beat.
//  - Bits sent:
//    - MSB-first: data[W-1] down to data[W-L].
//    - LSB-first: data[0] up to data[L-1].
//  - Beat count: B = ceil(L/LANES).
//    - Beats 0..B-2 carry LANES bits each.
//    - Beat B-1 carries k = L - (B-1)*LANES bits in the top k lanes. The other lanes are 0 and ser_lanes_o = k.
//  - Length filter: L in 1..MIN_LEN-1 is accepted (rdy high) and silently dropped. It produces no beats and busy_o is unaffected.
//  - States:
//    - IDLE: shifter empty, ser_data_val_o = 0.
//    - SHIFT: one beat per cycle; a beat counter counts down from B-1 to 0.
//    - At the end of SHIFT: go to SHIFT with the holding word if one is present, else go to IDLE.
//  - data_rdy_o is the negation of holding-full. It is registered, with no combinational path from data_val_i.
//  - Word routing on accept at posedge T:
//    - Shifter IDLE, or on its last beat in cycle T, with holding empty: the word goes to the shifter. Its first beat is output in cycle T+1 (latency 1).
//    - Otherwise: the word goes to holding, and data_rdy_o = 0 from T+1.
//  - Holding handoff: when the current last beat completes, the holding word enters the shifter.
//    - Its first beat is output in the very next cycle (no bubble).
//    - data_rdy_o rises in that same cycle.
//  - Dropped length while shifter busy: the word never occupies holding. rdy stays as it was.
//  - Capture time: data_lsb_first_i and data_mod_i are sampled with data_i at accept. Later changes to them do not affect that transaction.
//  - busy_o = (state == SHIFT) | holding_full, registered.
//  - Maximum throughput: one word per B cycles, sustained with no gaps.
//
// TESTING
//  - W=16, LANES=1, data=16'hA5C3, mod=0, MSB-first
//    -> 16 beats: 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; ser_last_o on beat 16; first beat in cycle T+1.
//  - W=16, LANES=4, data=16'h1234, mod=6, LSB-first
//    -> 2 beats: beat 0 ser_data=4'b0010 lanes=4 (data[0] on lane 3); beat 1 ser_data=4'b1100 lanes=2 last=1.
//  - mod=2 with val held one cycle
//    -> rdy stays 1, no beats, busy_o stays 0; a following mod=3 word then serialises normally.
//  - Three back-to-back words (mod=4, LANES=1) with val held high
//    -> 12 consecutive valid beats, no gap; rdy drops to 0 while holding is full; last asserted on beats 4, 8 and 12.
//  - srst_i pulsed mid-transaction, beat 5 of 16, with a word in holding
//    -> next cycle val=0, busy=0, rdy=1; the held word is never output.
//  - LANES=2, mod=0, MSB-first, data=16'hFFFF
//    -> 8 beats, each ser_data=2'b11 lanes=2; last on beat 8.

Source files
------------

// File: rtl/multilane_serializer.sv
//------------------------------------------------------------------------------
// Module   : multilane_serializer
// Function : Parallel-to-multilane serializer, MSB/LSB-first per word, with a
//            one-entry holding register for gap-free back-to-back streaming.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multilane_serializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4,
    parameter int LANES          = 1,
    parameter int MIN_LEN        = 3
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [DATA_BUS_WIDTH-1:0]  data_i,
    input  logic [DATA_MOD_WIDTH-1:0]  data_mod_i,
    input  logic                       data_lsb_first_i,
    input  logic                       data_val_i,
    output logic                       data_rdy_o,
    output logic [LANES-1:0]           ser_data_o,
    output logic [$clog2(LANES):0]     ser_lanes_o,
    output logic                       ser_data_val_o,
    output logic                       ser_last_o,
    output logic                       busy_o
);

    localparam int W    = DATA_BUS_WIDTH;
    localparam int LW   = $clog2(LANES) + 1;
    localparam int LENW = DATA_MOD_WIDTH + 1;
    localparam int LSH  = $clog2(LANES);

    localparam logic [LENW-1:0] c_W_LEN   = LENW'(W);
    localparam logic [LENW-1:0] c_MIN_LEN = LENW'(MIN_LEN);
    localparam logic [LENW-1:0] c_ONE     = LENW'(1);
    localparam logic [LW-1:0]   c_LANES   = LW'(LANES);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      sh_q, sh_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]     k_q, k_d;
    logic [W-1:0]      hold_word_q, hold_word_d;
    logic [LENW-1:0]   hold_len_q, hold_len_d;
    logic              hold_full_q, hold_full_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic [LANES-1:0]  ser_data_q, ser_data_d;
    logic [LW-1:0]     lanes_q, lanes_d;
    logic              val_q, val_d;
    logic              last_q, last_d;

    function automatic logic [W-1:0] reverse_bits(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        return r;
    endfunction

    // Selects the top k lanes of a beat; k == LANES keeps all of them.
    function automatic logic [LANES-1:0] top_mask(input logic [LW-1:0] k);
        logic [LANES-1:0] ones;
        ones = '1;
        return ~(ones >> k);
    endfunction

    logic             accept;
    logic [LENW-1:0]  in_len;
    logic             in_take;
    logic [W-1:0]     in_word;
    logic             shifter_free;
    logic [W-1:0]     ld_word;
    logic [LENW-1:0]  ld_len;
    logic [LENW-1:0]  ld_m1;
    logic [LW-1:0]    ld_k;
    logic             ld_single;
    logic             next_last;

    // Words are stored bit-reversed when LSB-first so the shifter always drains from the top.
    assign accept       = data_val_i & rdy_q;
    assign in_len       = (data_mod_i == '0) ? c_W_LEN : {1'b0, data_mod_i};
    assign in_take      = accept & (in_len >= c_MIN_LEN);
    assign in_word      = data_lsb_first_i ? reverse_bits(data_i) : data_i;
    assign shifter_free = (state_q == S_IDLE) || (cnt_q == '0);
    assign ld_word      = hold_full_q ? hold_word_q : in_word;
    assign ld_len       = hold_full_q ? hold_len_q  : in_len;
    assign ld_m1        = (ld_len - c_ONE) >> LSH;
    assign ld_k         = LW'(ld_len - (ld_m1 << LSH));
    assign ld_single    = (ld_m1 == '0);
    assign next_last    = (cnt_q == c_ONE);

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        hold_word_d = hold_word_q;
        hold_len_d  = hold_len_q;
        hold_full_d = hold_full_q;
        ser_data_d  = '0;
        lanes_d     = '0;
        val_d       = 1'b0;
        last_d      = 1'b0;

        if (shifter_free) begin
            if (hold_full_q || in_take) begin
                state_d     = S_SHIFT;
                sh_d        = ld_word << LANES;
                cnt_d       = ld_m1;
                k_d         = ld_k;
                hold_full_d = 1'b0;
                ser_data_d  = ld_word[W-1 -: LANES] & (ld_single ? top_mask(ld_k) : '1);
                lanes_d     = ld_single ? ld_k : c_LANES;
                val_d       = 1'b1;
                last_d      = ld_single;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            sh_d       = sh_q << LANES;
            cnt_d      = cnt_q - c_ONE;
            ser_data_d = sh_q[W-1 -: LANES] & (next_last ? top_mask(k_q) : '1);
            lanes_d    = next_last ? k_q : c_LANES;
            val_d      = 1'b1;
            last_d     = next_last;
            if (in_take) begin
                hold_word_d = in_word;
                hold_len_d  = in_len;
                hold_full_d = 1'b1;
            end
        end

        rdy_d  = ~hold_full_d;
        busy_d = (state_d == S_SHIFT) | hold_full_d;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            hold_word_q <= '0;
            hold_len_q  <= '0;
            hold_full_q <= 1'b0;
            rdy_q       <= 1'b1;
            busy_q      <= 1'b0;
            ser_data_q  <= '0;
            lanes_q     <= '0;
            val_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            hold_word_q <= hold_word_d;
            hold_len_q  <= hold_len_d;
            hold_full_q <= hold_full_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
            ser_data_q  <= ser_data_d;
            lanes_q     <= lanes_d;
            val_q       <= val_d;
            last_q      <= last_d;
        end
    end

    assign data_rdy_o     = rdy_q;
    assign ser_data_o     = ser_data_q;
    assign ser_lanes_o    = lanes_q;
    assign ser_data_val_o = val_q;
    assign ser_last_o     = last_q;
    assign busy_o         = busy_q;

endmodule

`default_nettype wire
